// File: rtl/dual_port_ssram_arb.sv
// Dual-port synchronous SRAM with request/ack handshake, byte-lane writes and fair
// write/write collision arbitration. Define DUAL_PORT_SSRAM_BYPASS_EN for same-cycle write-to-read forwarding.
module dual_port_ssram_arb #(
  parameter int unsigned BITWIDTH      = 32,
  parameter int unsigned NR_OF_ENTRIES = 512,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                             clock,
  input  logic                             nReset,
  input  logic                             requestA,
  input  logic                             writeA,
  input  logic [BITWIDTH/8-1:0]            byteEnableA,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0] addressA,
  input  logic [BITWIDTH-1:0]              dataInA,
  input  logic                             requestB,
  input  logic                             writeB,
  input  logic [BITWIDTH/8-1:0]            byteEnableB,
  input  logic [$clog2(NR_OF_ENTRIES)-1:0] addressB,
  input  logic [BITWIDTH-1:0]              dataInB,
  output logic                             ackA,
  output logic                             ackB,
  output logic [BITWIDTH-1:0]              dataOutA,
  output logic [BITWIDTH-1:0]              dataOutB,
  output logic                             dataValidA,
  output logic                             dataValidB,
  output logic [15:0]                      collisionCount
);

  localparam int unsigned NB = BITWIDTH / 8;

  logic [BITWIDTH-1:0] mem [NR_OF_ENTRIES];
  logic                prio_b;
  logic                collision_c;
  logic                wr_a_c, wr_b_c, rd_a_c, rd_b_c;
  logic [BITWIDTH-1:0] rdword_a_c, rdword_b_c;
  logic                pv_a, pv_b;
  logic [BITWIDTH-1:0] pd_a, pd_b;

  // Replace enabled byte lanes of a word with new data.
  function automatic logic [BITWIDTH-1:0] merge_lanes(input logic [BITWIDTH-1:0] old_w,
                                                      input logic [BITWIDTH-1:0] new_w,
                                                      input logic [NB-1:0]       be);
    logic [BITWIDTH-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Arbitration: only a same-address write/write pair stalls the non-priority port.
  always_comb begin
    collision_c = requestA & requestB & writeA & writeB & (addressA == addressB);
    ackA        = requestA & ~(collision_c & prio_b);
    ackB        = requestB & ~(collision_c & ~prio_b);
    wr_a_c      = ackA & writeA & nReset;
    wr_b_c      = ackB & writeB & nReset;
    rd_a_c      = ackA & ~writeA;
    rd_b_c      = ackB & ~writeB;
`ifdef DUAL_PORT_SSRAM_BYPASS_EN
    rdword_a_c  = (wr_b_c && (addressB == addressA)) ?
                  merge_lanes(mem[addressA], dataInB, byteEnableB) : mem[addressA];
    rdword_b_c  = (wr_a_c && (addressA == addressB)) ?
                  merge_lanes(mem[addressB], dataInA, byteEnableA) : mem[addressB];
`else
    rdword_a_c  = mem[addressA];
    rdword_b_c  = mem[addressB];
`endif
  end

  // Storage is deliberately unreset; reset only gates the write enables.
  always_ff @(posedge clock) begin
    if (wr_a_c) mem[addressA] <= merge_lanes(mem[addressA], dataInA, byteEnableA);
    if (wr_b_c) mem[addressB] <= merge_lanes(mem[addressB], dataInB, byteEnableB);
  end

  // The loser of each collision gains priority, so the flag toggles per collision.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      prio_b         <= 1'b0;
      collisionCount <= 16'd0;
    end else if (collision_c) begin
      prio_b <= ~prio_b;
      if (collisionCount != 16'hFFFF) collisionCount <= collisionCount + 16'd1;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                sv_a, sv_b;
    logic [BITWIDTH-1:0] sd_a, sd_b;

    always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
        sv_a <= 1'b0;
        sv_b <= 1'b0;
        sd_a <= '0;
        sd_b <= '0;
      end else begin
        sv_a <= rd_a_c;
        sv_b <= rd_b_c;
        if (rd_a_c) sd_a <= rdword_a_c;
        if (rd_b_c) sd_b <= rdword_b_c;
      end
    end

    always_comb begin
      pv_a = sv_a;
      pv_b = sv_b;
      pd_a = sd_a;
      pd_b = sd_b;
    end
  end else if (READ_LATENCY == 1) begin : g_lat1
    always_comb begin
      pv_a = rd_a_c;
      pv_b = rd_b_c;
      pd_a = rdword_a_c;
      pd_b = rdword_b_c;
    end
  end else begin : g_lat_bad
    $error("dual_port_ssram_arb: READ_LATENCY must be 1 or 2");
    always_comb begin
      pv_a = 1'b0;
      pv_b = 1'b0;
      pd_a = '0;
      pd_b = '0;
    end
  end

  // Final output stage: data holds until the next valid read.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      dataValidA <= 1'b0;
      dataValidB <= 1'b0;
      dataOutA   <= '0;
      dataOutB   <= '0;
    end else begin
      dataValidA <= pv_a;
      dataValidB <= pv_b;
      if (pv_a) dataOutA <= pd_a;
      if (pv_b) dataOutB <= pd_b;
    end
  end

endmodule

// File: tb/tb_dual_port_ssram_arb.sv
// Self-checking bench for dual_port_ssram_arb: directed test-plan cases plus randomized
// traffic against a cycle-scheduled reference model.
module tb_dual_port_ssram_arb;

  localparam int unsigned LAT   = 2;
  localparam int unsigned SLOTS = 64;

  logic        clock;
  logic        nReset;
  logic        reqA, wrA, reqB, wrB;
  logic [3:0]  beA, beB;
  logic [8:0]  adA, adB;
  logic [31:0] diA, diB;
  logic        ackA, ackB, dataValidA, dataValidB;
  logic [31:0] dataOutA, dataOutB;
  logic [15:0] collisionCount;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] ref_mem [512];
  logic        sched_va [SLOTS];
  logic        sched_vb [SLOTS];
  logic [31:0] sched_da [SLOTS];
  logic [31:0] sched_db [SLOTS];
  logic [31:0] held_a, held_b;
  logic        turn_b;
  int          m_count;

  // Observations from the most recent step
  logic        obs_ackA, obs_ackB, obs_vA, obs_vB;
  logic [31:0] obs_dA, obs_dB;
  logic [15:0] obs_count;

  dual_port_ssram_arb #(
    .BITWIDTH      (32),
    .NR_OF_ENTRIES (512),
    .READ_LATENCY  (LAT)
  ) dut (
    .clock          (clock),
    .nReset         (nReset),
    .requestA       (reqA),
    .writeA         (wrA),
    .byteEnableA    (beA),
    .addressA       (adA),
    .dataInA        (diA),
    .requestB       (reqB),
    .writeB         (wrB),
    .byteEnableB    (beB),
    .addressB       (adB),
    .dataInB        (diB),
    .ackA           (ackA),
    .ackB           (ackB),
    .dataOutA       (dataOutA),
    .dataOutB       (dataOutB),
    .dataValidA     (dataValidA),
    .dataValidB     (dataValidB),
    .collisionCount (collisionCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] pf(input int i);
    return 32'hA500_0000 | 32'(i * 32'h0001_0101);
  endfunction

  task automatic set_a(input logic r, input logic w, input logic [3:0] be, input logic [8:0] a,
                       input logic [31:0] d);
    reqA = r; wrA = w; beA = be; adA = a; diA = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [3:0] be, input logic [8:0] a,
                       input logic [31:0] d);
    reqB = r; wrB = w; beB = be; adB = a; diB = d;
  endtask

  task automatic idle_both();
    set_a(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(SLOTS); i++) begin
      sched_va[i] = 1'b0; sched_vb[i] = 1'b0;
      sched_da[i] = 32'h0; sched_db[i] = 32'h0;
    end
    held_a = 32'h0; held_b = 32'h0;
    turn_b = 1'b0; m_count = 0;
  endtask

  // One clock cycle: compare outputs at negedge, then advance the model across the next edge.
  task automatic step();
    logic        coll, ea, eb;
    logic [31:0] wa, wb;
    int          slot, fut;
    @(negedge clock);
    coll = reqA && reqB && wrA && wrB && (adA == adB);
    ea   = reqA && !(coll && turn_b);
    eb   = reqB && !(coll && !turn_b);
    slot = cyc % int'(SLOTS);
    if (sched_va[slot]) held_a = sched_da[slot];
    if (sched_vb[slot]) held_b = sched_db[slot];
    obs_ackA = ackA; obs_ackB = ackB; obs_vA = dataValidA; obs_vB = dataValidB;
    obs_dA = dataOutA; obs_dB = dataOutB; obs_count = collisionCount;
    check("ackA", 32'(ackA), 32'(ea));
    check("ackB", 32'(ackB), 32'(eb));
    check("validA", 32'(dataValidA), 32'(sched_va[slot]));
    check("validB", 32'(dataValidB), 32'(sched_vb[slot]));
    check("doutA", dataOutA, held_a);
    check("doutB", dataOutB, held_b);
    check("ccount", 32'(collisionCount), 32'(m_count));
    sched_va[slot] = 1'b0;
    sched_vb[slot] = 1'b0;
    if (nReset) begin
      fut = (cyc + int'(LAT)) % int'(SLOTS);
      wa  = ref_mem[adA];
      wb  = ref_mem[adB];
`ifdef DUAL_PORT_SSRAM_BYPASS_EN
      if (eb && wrB && adB == adA) wa = lane_merge(wa, diB, beB);
      if (ea && wrA && adA == adB) wb = lane_merge(wb, diA, beA);
`endif
      if (ea && !wrA) begin sched_va[fut] = 1'b1; sched_da[fut] = wa; end
      if (eb && !wrB) begin sched_vb[fut] = 1'b1; sched_db[fut] = wb; end
      if (ea && wrA) ref_mem[adA] = lane_merge(ref_mem[adA], diA, beA);
      if (eb && wrB) ref_mem[adB] = lane_merge(ref_mem[adB], diB, beB);
      if (coll) begin
        turn_b = !turn_b;
        if (m_count < 65535) m_count++;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic write_a(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    set_a(1'b1, 1'b1, be, a, d);
    step();
    idle_both();
  endtask

  // Bounded wait for a read result on one port; returns cycles waited.
  task automatic wait_valid(input bit port_b, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!(port_b ? obs_vB : obs_vA) && k < 6);
  endtask

  task automatic read_word(input bit port_b, input logic [8:0] a, input string tag,
                           input logic [31:0] exp);
    int k;
    if (port_b) set_b(1'b1, 1'b0, 4'h0, a, 32'h0);
    else        set_a(1'b1, 1'b0, 4'h0, a, 32'h0);
    step();
    idle_both();
    wait_valid(port_b, k);
    check({tag, "_lat"}, 32'(k), 32'(LAT));
    check(tag, port_b ? obs_dB : obs_dA, exp);
  endtask

  initial begin
    int  k;
    bit  pa, pb;
    logic [31:0] exp_byp;

    nReset = 1'b0;
    idle_both();
    model_reset();
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'hx;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_validA", 32'(dataValidA), 32'h0);
    check("rst_validB", 32'(dataValidB), 32'h0);
    check("rst_doutA", dataOutA, 32'h0);
    check("rst_doutB", dataOutB, 32'h0);
    check("rst_count", 32'(collisionCount), 32'h0);
    @(posedge clock);
    #1;
    nReset = 1'b1;

    for (int i = 0; i < 16; i++) write_a(9'(i), pf(i), 4'hF);

    // Write then read on the other port
    write_a(9'd5, 32'hDEAD_BEEF, 4'hF);
    read_word(1'b1, 9'd5, "t1_rdB", 32'hDEAD_BEEF);

    // Byte-lane merge and all-zero enable
    write_a(9'd7, 32'h1122_3344, 4'hF);
    write_a(9'd7, 32'hAABB_CCDD, 4'h5);
    read_word(1'b0, 9'd7, "t2_lanes", 32'h11BB_33DD);
    write_a(9'd7, 32'h0000_0000, 4'h0);
    read_word(1'b1, 9'd7, "t2_be0", 32'h11BB_33DD);

    // Same-cycle write A / read B at one address
    write_a(9'd9, 32'h0, 4'hF);
    set_a(1'b1, 1'b1, 4'hF, 9'd9, 32'hFFFF_FFFF);
    set_b(1'b1, 1'b0, 4'h0, 9'd9, 32'h0);
    step();
    idle_both();
    wait_valid(1'b1, k);
`ifdef DUAL_PORT_SSRAM_BYPASS_EN
    exp_byp = 32'hFFFF_FFFF;
`else
    exp_byp = 32'h0000_0000;
`endif
    check("t4_bypass", obs_dB, exp_byp);
    read_word(1'b1, 9'd9, "t4_after", 32'hFFFF_FFFF);

    // Reset asserted with reads in flight
    set_a(1'b1, 1'b0, 4'h0, 9'd10, 32'h0); step();
    set_a(1'b1, 1'b0, 4'h0, 9'd11, 32'h0); step();
    nReset = 1'b0;
    model_reset();
    set_a(1'b1, 1'b0, 4'h0, 9'd12, 32'h0); step();
    check("t5_v0", 32'(obs_vA), 32'h0);
    check("t5_d0", obs_dA, 32'h0);
    set_a(1'b1, 1'b0, 4'h0, 9'd13, 32'h0); step();
    idle_both();
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_vq", 32'(obs_vA), 32'h0);
      check("t5_dq", obs_dA, 32'h0);
    end
    for (int i = 10; i < 14; i++) read_word(1'b0, 9'(i), "t5_mem", pf(i));

    // Continuous collision: strict alternation
    set_a(1'b1, 1'b1, 4'hF, 9'd3, 32'h1);
    set_b(1'b1, 1'b1, 4'hF, 9'd3, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_ackA", 32'(obs_ackA), 32'((i % 2) == 0));
      check("t3_ackB", 32'(obs_ackB), 32'((i % 2) == 1));
    end
    set_a(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
    step();
    check("t3_ackB_last", 32'(obs_ackB), 32'h1);
    check("t3_count", 32'(obs_count), 32'd3);
    idle_both();
    read_word(1'b0, 9'd3, "t3_mem", 32'h2);

    // Randomized traffic with hold-until-ack requesters
    pa = 1'b0; pb = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!pa) begin
        if ($urandom_range(0, 9) < 7) begin
          set_a(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom_range(0, 7)), $urandom);
          pa = 1'b1;
        end else set_a(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
      end
      if (!pb) begin
        if ($urandom_range(0, 9) < 7) begin
          set_b(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom_range(0, 7)), $urandom);
          pb = 1'b1;
        end else set_b(1'b0, 1'b0, 4'h0, 9'd0, 32'h0);
      end
      step();
      if (pa && obs_ackA) pa = 1'b0;
      if (pb && obs_ackB) pb = 1'b0;
    end
    idle_both();
    for (int i = 0; i < 4; i++) step();

    // Saturation of the collision counter
    set_a(1'b1, 1'b1, 4'hF, 9'd100, 32'h5);
    set_b(1'b1, 1'b1, 4'hF, 9'd100, 32'h6);
    for (int i = 0; i < 65540; i++) step();
    idle_both();
    step();
    check("sat_count", 32'(obs_count), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
